// File: rtl/nonsynth_eth_pkg.sv
// Shared types and constants for the Ethernet RX frame buffer.
package nonsynth_eth_pkg;

  localparam int eth_max_frame_bytes_gp = 1560;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_RECV    = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    DROP_NONE     = 2'd0,
    DROP_FULL     = 2'd1,
    DROP_BAD      = 2'd2,
    DROP_OVERSIZE = 2'd3
  } drop_reason_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nonsynth_eth_keep_count.sv
// Trailing-ones count of a tkeep vector plus a flag telling whether the
// enabled bytes form one contiguous run starting at byte 0.
module nonsynth_eth_keep_count #(
  parameter int data_width_p = 8,
  localparam int cnt_w_lp = $clog2(data_width_p + 1)
) (
  input  logic [data_width_p-1:0] keep_i,
  output logic [cnt_w_lp-1:0]     count_o,
  output logic                    contig_o
);

  logic run;

  always_comb begin
    count_o = '0;
    run     = 1'b1;
    for (int i = 0; i < data_width_p; i++) begin
      if (run && keep_i[i]) count_o = count_o + 1'b1;
      else                  run     = 1'b0;
    end
  end

  // x & (x+1) clears the low run of ones; anything left is a gap
  assign contig_o = ((keep_i & (keep_i + 1'b1)) == '0);

endmodule

// File: rtl/nonsynth_ethernet_rx_frame_buffer.sv
// AXI-stream Ethernet RX frame buffer: never backpressures, drops frames instead.
// Drop counters exist only when NONSYNTH_ETH_RX_DROP_CNT_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for the first beat of a frame
//   RECV    | writing beats of an accepted frame into slot wr_ptr
//   DISCARD | swallowing the rest of a dropped frame until tlast
module nonsynth_ethernet_rx_frame_buffer
  import nonsynth_eth_pkg::*;
#(
  parameter int data_width_p = 8,
  parameter int slots_p      = 4,
  parameter int slot_bytes_p = eth_max_frame_bytes_gp,
  localparam int slot_words_lp = (slot_bytes_p + data_width_p - 1) / data_width_p,
  localparam int addr_w_lp     = (slot_words_lp > 1) ? $clog2(slot_words_lp) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [data_width_p*8-1:0] rx_axis_tdata_i,
  input  logic [data_width_p-1:0]   rx_axis_tkeep_i,
  input  logic                      rx_axis_tvalid_i,
  input  logic                      rx_axis_tlast_i,
  input  logic                      rx_axis_tuser_i,
  output logic                      rx_axis_tready_o,
  output logic                      frame_v_o,
  output logic [15:0]               frame_size_o,
  input  logic [addr_w_lp-1:0]      rd_addr_i,
  output logic [data_width_p*8-1:0] rd_data_o,
  input  logic                      frame_pop_i,
  output logic [15:0]               drop_full_o,
  output logic [15:0]               drop_bad_o,
  output logic [15:0]               drop_oversize_o
);

  localparam int wp_w_lp  = $clog2(slot_words_lp + 1);
  localparam int sp_w_lp  = $clog2(slots_p);
  localparam int occ_w_lp = $clog2(slots_p + 1);
  localparam int kc_w_lp  = $clog2(data_width_p + 1);

  localparam logic [1:0] IDLE    = WR_IDLE;
  localparam logic [1:0] RECV    = WR_RECV;
  localparam logic [1:0] DISCARD = WR_DISCARD;

  localparam logic [wp_w_lp-1:0]  cap_lp   = wp_w_lp'(slot_words_lp);
  localparam logic [occ_w_lp-1:0] slots_lp = occ_w_lp'(slots_p);

  logic [1:0]                state_q, state_d;
  logic [wp_w_lp-1:0]        word_ptr_q, word_ptr_d;
  logic [sp_w_lp-1:0]        wr_ptr_q, rd_ptr_q;
  logic [occ_w_lp-1:0]       occ_q;
  logic                      ready_q;

  logic [data_width_p*8-1:0] mem [slots_p][slot_words_lp];
  logic [15:0]               size_mem [slots_p];

  logic                      beat_fire, full, frame_v, pop_fire;
  logic                      wr_en, commit;
  logic [addr_w_lp-1:0]      wr_addr;
  drop_reason_e              drop_reason;
  logic [kc_w_lp-1:0]        keep_cnt;
  logic                      keep_contig;
  logic [15:0]               commit_size;

  nonsynth_eth_keep_count #(
    .data_width_p(data_width_p)
  ) u_keep_count (
    .keep_i  (rx_axis_tkeep_i),
    .count_o (keep_cnt),
    .contig_o(keep_contig)
  );

  assign beat_fire   = rx_axis_tvalid_i && ready_q;
  assign full        = (occ_q == slots_lp);
  assign frame_v     = (occ_q != '0);
  assign pop_fire    = frame_pop_i && frame_v;
  assign commit_size = 16'(word_ptr_q) * 16'(data_width_p) + 16'(keep_cnt);

  always_comb begin
    state_d     = state_q;
    word_ptr_d  = word_ptr_q;
    wr_en       = 1'b0;
    wr_addr     = word_ptr_q[addr_w_lp-1:0];
    commit      = 1'b0;
    drop_reason = DROP_NONE;
    if (beat_fire) begin
      case (state_q)
        IDLE: begin
          // full is judged on registered occupancy, so a same-cycle pop cannot help
          if (full) begin
            drop_reason = DROP_FULL;
            state_d     = rx_axis_tlast_i ? IDLE : DISCARD;
          end else begin
            wr_en   = 1'b1;
            wr_addr = '0;
            if (rx_axis_tlast_i) begin
              word_ptr_d = '0;
              if (rx_axis_tuser_i) drop_reason = DROP_BAD;
              else                 commit      = 1'b1;
            end else begin
              state_d    = RECV;
              word_ptr_d = wp_w_lp'(1);
            end
          end
        end
        RECV: begin
          if (rx_axis_tlast_i && rx_axis_tuser_i) begin
            drop_reason = DROP_BAD;
            state_d     = IDLE;
            word_ptr_d  = '0;
          end else if (word_ptr_q == cap_lp) begin
            drop_reason = DROP_OVERSIZE;
            state_d     = rx_axis_tlast_i ? IDLE : DISCARD;
            word_ptr_d  = '0;
          end else begin
            wr_en = 1'b1;
            if (rx_axis_tlast_i) begin
              commit     = 1'b1;
              state_d    = IDLE;
              word_ptr_d = '0;
            end else begin
              word_ptr_d = word_ptr_q + 1'b1;
            end
          end
        end
        DISCARD: begin
          if (rx_axis_tlast_i) state_d = IDLE;
        end
        default: begin
          state_d    = IDLE;
          word_ptr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      word_ptr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      state_q    <= state_d;
      word_ptr_q <= word_ptr_d;
      if (commit)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (commit && !pop_fire)      occ_q <= occ_q + 1'b1;
      else if (pop_fire && !commit) occ_q <= occ_q - 1'b1;
    end
  end

  // Slot storage and sizes are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en)  mem[wr_ptr_q][wr_addr] <= rx_axis_tdata_i;
    if (commit) size_mem[wr_ptr_q]     <= commit_size;
  end

  assign rx_axis_tready_o = ready_q;
  assign frame_v_o        = frame_v;
  assign frame_size_o     = frame_v ? size_mem[rd_ptr_q] : 16'h0;
  assign rd_data_o        = mem[rd_ptr_q][rd_addr_i];

`ifdef NONSYNTH_ETH_RX_DROP_CNT_EN
  logic [15:0] drop_full_q, drop_bad_q, drop_oversize_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_full_q     <= '0;
      drop_bad_q      <= '0;
      drop_oversize_q <= '0;
    end else begin
      case (drop_reason)
        DROP_FULL:     drop_full_q     <= sat_inc16(drop_full_q);
        DROP_BAD:      drop_bad_q      <= sat_inc16(drop_bad_q);
        DROP_OVERSIZE: drop_oversize_q <= sat_inc16(drop_oversize_q);
        default: ;
      endcase
    end
  end

  assign drop_full_o     = drop_full_q;
  assign drop_bad_o      = drop_bad_q;
  assign drop_oversize_o = drop_oversize_q;
`else
  logic unused_drop_reason;
  assign unused_drop_reason = ^drop_reason;
  assign drop_full_o        = 16'h0;
  assign drop_bad_o         = 16'h0;
  assign drop_oversize_o    = 16'h0;
`endif

  // Simulation-only protocol checks on the incoming stream and pop handshake.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (beat_fire && rx_axis_tlast_i && !keep_contig)
        $error("rx frame buffer: non-contiguous tkeep %h on last beat", rx_axis_tkeep_i);
      if (beat_fire && !rx_axis_tlast_i && !(&rx_axis_tkeep_i))
        $error("rx frame buffer: partial tkeep %h on non-last beat", rx_axis_tkeep_i);
      if (frame_pop_i && !frame_v)
        $warning("rx frame buffer: frame_pop_i ignored, no frame buffered");
    end
  end

endmodule

// File: doc/nonsynth_ethernet_rx_frame_buffer.md
NONSYNTH_ETHERNET_RX_FRAME_BUFFER -- requirements
Module: nonsynth_ethernet_rx_frame_buffer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- data_width_p, 8: beat width in bytes; legal values 1, 2, 4, 8.
- slots_p, 4: frame slots; power of two, at least 2.
- slot_bytes_p, 1560: bytes per slot; rounded up internally to a multiple of data_width_p.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- reset_n_i, in, 1: reset, asynchronous, active-low.
- rx_axis_tdata_i, in, data_width_p*8: stream data.
- rx_axis_tkeep_i, in, data_width_p: byte enables.
- rx_axis_tvalid_i, in, 1: beat valid.
- rx_axis_tlast_i, in, 1: last beat of frame.
- rx_axis_tuser_i, in, 1: bad-frame flag; meaningful on the last beat only.
- rx_axis_tready_o, out, 1: beat accept.
- frame_v_o, out, 1: at least one committed frame is buffered.
- frame_size_o, out, 16: byte length of the head frame.
- rd_addr_i, in, clog2(slot words): word index into the head frame.
- rd_data_o, out, data_width_p*8: head-frame word at rd_addr_i.
- frame_pop_i, in, 1: release the head frame.
- drop_full_o, drop_bad_o, drop_oversize_o, out, 16 each: drop counters.

Function
REQ-003 rx_axis_tready_o SHALL be constant 1 out of reset; the block never backpressures and drops frames instead.
REQ-004 The write FSM SHALL have three states: IDLE, RECV and DISCARD.
REQ-005 In IDLE, a beat with at least one free slot SHALL be written to word 0 of slot wr_ptr; the FSM goes to RECV, or commits immediately if tlast=1 and tuser=0.
REQ-006 In IDLE, a beat with all slots_p slots occupied SHALL increment drop_full_o; the FSM goes to DISCARD, or stays in IDLE if tlast=1.
REQ-007 In RECV, each beat SHALL be written at word_ptr, and word_ptr SHALL then increment.
REQ-008 In RECV, a beat arriving when word_ptr equals slot capacity SHALL increment drop_oversize_o; the FSM goes to DISCARD, or to IDLE if tlast=1.
REQ-009 A last beat with tuser=1 (IDLE or RECV) SHALL discard the frame, increment drop_bad_o, return the FSM to IDLE, and reset word_ptr to 0.
REQ-010 In DISCARD, beats SHALL be consumed without being written, and the FSM SHALL return to IDLE on tlast.
REQ-011 Commit SHALL record size = word_ptr*data_width_p + (count of trailing ones in tkeep), advance wr_ptr modulo slots_p, and increment the occupancy count.
REQ-012 The committed frame SHALL be visible on frame_v_o/frame_size_o in the cycle after the last beat.
REQ-013 A non-contiguous tkeep on the last beat SHALL raise $error, and its size SHALL be computed by the trailing-ones rule.
REQ-014 A non-all-ones tkeep on a non-last beat SHALL raise $error.
REQ-015 rd_data_o SHALL be a combinational read of slot rd_ptr at word rd_addr_i; it is undefined when frame_v_o=0.
REQ-016 frame_pop_i with frame_v_o=1 SHALL advance rd_ptr modulo slots_p and decrement occupancy.
REQ-017 frame_pop_i with frame_v_o=0 SHALL be ignored and SHALL raise $warning.
REQ-018 When a commit and a pop occur in the same cycle, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-019 A commit that fills the last free slot SHALL make the next frame start a drop_full case.
REQ-020 A pop in the same cycle as a new frame's first beat SHALL NOT free that slot for this beat; full is evaluated on registered occupancy.
REQ-021 Drop counters SHALL saturate at 16'hFFFF.

Reset
REQ-022 On reset_n_i low, asynchronously: FSM=IDLE; wr_ptr, rd_ptr, word_ptr and occupancy=0; frame_v_o=0; frame_size_o=0; all drop counters=0; rx_axis_tready_o=0.
REQ-023 Slot storage SHALL NOT be reset.
REQ-024 A frame in progress at reset SHALL be lost; beats after reset release SHALL be treated as a new frame start.

Configuration
REQ-025 With NONSYNTH_ETH_RX_DROP_CNT_EN defined, the three counters SHALL operate as in REQ-006, REQ-008, REQ-009 and REQ-021.
REQ-026 Without NONSYNTH_ETH_RX_DROP_CNT_EN, the counter registers SHALL be absent and drop_*_o SHALL be tied to 16'h0; frame handling SHALL be identical.

Structure
REQ-027 Package nonsynth_eth_pkg SHALL hold the FSM state enum, the drop-reason enum and the constant eth_max_frame_bytes_gp = 1560.
REQ-028 Sub-module nonsynth_eth_keep_count SHALL compute the trailing-ones count and the contiguity flag from tkeep, parameterised by data_width_p.

Verification
REQ-029 With defaults, a single 64-byte good frame (8 beats, last tkeep 8'hFF) SHALL yield frame_v_o=1 and frame_size_o=64 one cycle after tlast; the words SHALL match at rd_addr 0..7.
REQ-030 A 61-byte frame (last tkeep 8'h1F) SHALL yield frame_size_o=61; pop SHALL then give frame_v_o=0.
REQ-031 Five back-to-back 64-byte frames with no pop SHALL give four buffered and drop_full_o=1; after four pops, sizes SHALL read 64 in order.
REQ-032 A frame with tuser=1 on the last beat SHALL give drop_bad_o=1 and frame_v_o unchanged; a following good 60-byte frame SHALL be stored in the same slot.
REQ-033 A 1600-byte frame SHALL give drop_oversize_o=1 with nothing committed; the next 64-byte frame SHALL be accepted.
REQ-034 Commit coinciding with a pop at occupancy 1 SHALL keep occupancy at 1 with the new head size; reset_n_i low mid-frame, then a 64-byte frame, SHALL give exactly one frame of size 64.
